// File: rtl/tinyalu_driver_if.sv
// Command/response port of the tinyalu driver, plus the driver-to-ALU pin bundle.
// Master drives the request side of each bundle; slave answers it.
interface tinyalu_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout
    );
endinterface

interface tinyalu_if;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;

    modport master (
        output alu_a, alu_b, alu_op, alu_start, alu_reset_n,
        input  alu_done, alu_result
    );
    modport slave (
        input  alu_a, alu_b, alu_op, alu_start, alu_reset_n,
        output alu_done, alu_result
    );
endinterface

// File: rtl/tinyalu_driver.sv
// Purpose: initiator for the tinyalu start/done protocol; one command in flight, single-entry response.
// Latency: accept T, start T+1, response valid the cycle after done (or after timeout / reset pulse).
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module tinyalu_driver #(
    parameter int TIMEOUT    = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    tinyalu_driver_if.slave  cmd,
    tinyalu_if.master        alu
);
    typedef enum logic [2:0] {IDLE, BUSY, NOP, RST, RESP} state_t;

    localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_RST = 3'b111;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          accept, finish, fin_timeout, start_c;
    logic [15:0]   fin_result;
    logic [7:0]    a_q, b_q;
    logic [2:0]    op_q, rsp_op_q;
    logic [15:0]   rsp_result_q;
    logic          rsp_timeout_q;

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        finish      = 1'b0;
        fin_timeout = 1'b0;
        fin_result  = '0;
        start_c     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    accept = 1'b1;
                    if (cmd.cmd_op == OP_RST)      state_n = RST;
                    else if (cmd.cmd_op == OP_NOP) state_n = NOP;
                    else                           state_n = BUSY;
                end
            end
            BUSY: begin
                // start is masked by done so a one-cycle op never sees a second start
                start_c = ~alu.alu_done;
                if (alu.alu_done) begin
                    finish     = 1'b1;
                    fin_result = alu.alu_result;
                    state_n    = RESP;
                end else if (cnt == TO_LAST) begin
                    finish      = 1'b1;
                    fin_timeout = 1'b1;
                    state_n     = RESP;
                end
            end
            NOP: begin
                start_c = 1'b1;
                finish  = 1'b1;
                state_n = RESP;
            end
            RST: begin
                if (cnt == RST_LAST) begin
                    finish  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (cmd.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rsp_result_q  <= '0;
            rsp_op_q      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt  <= '0;
                a_q  <= cmd.cmd_a;
                b_q  <= cmd.cmd_b;
                op_q <= cmd.cmd_op;
            end else if (state == BUSY || state == RST) begin
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                rsp_result_q  <= fin_result;
                rsp_op_q      <= op_q;
                rsp_timeout_q <= fin_timeout;
            end
        end
    end

    assign cmd.cmd_ready   = (state == IDLE) && !reset;
    assign cmd.rsp_valid   = (state == RESP);
    assign cmd.rsp_result  = rsp_result_q;
    assign cmd.rsp_op      = rsp_op_q;
    assign cmd.rsp_timeout = rsp_timeout_q;
    assign alu.alu_a       = a_q;
    assign alu.alu_b       = b_q;
    assign alu.alu_op      = op_q;
    assign alu.alu_start   = start_c;
    assign alu.alu_reset_n = (state != RST);
endmodule
